arbitro_scheduler: RTL

ARBITRO_SCHEDULER -- requirements
Module: arbitro_scheduler

---
 rtl/arbitro_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/arbitro_scheduler.sv
// Four-input scheduler: picks one eligible show-ahead FIFO per cycle and forwards its head word one cycle later.
// Optional macro ARB_STRICT_PRIO_EN selects fixed priority 0>1>2>3 instead of round-robin.
module arbitro_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fifo_empty,
  input  logic [5:0] fifo_data0,
  input  logic [5:0] fifo_data1,
  input  logic [5:0] fifo_data2,
  input  logic [5:0] fifo_data3,
  input  logic [3:0] dest_almost_full,
  output logic [3:0] pop,
  output logic       push,
  output logic [5:0] data_out,
  output logic [1:0] dest_sel,
  output logic [1:0] state,
  output logic       stall_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_push_p1;
  logic [5:0] r_data_p1;
  logic [1:0] r_dsel_p1;
  logic [7:0] r_stall_cnt;
  logic       r_stall_err;

  logic [5:0] w_head [4];
  logic [3:0] w_elig;
  logic       w_gnt_vld;
  logic [1:0] w_gnt_idx;
  logic [7:0] w_cnt_nxt;

  assign w_head[0] = fifo_data0;
  assign w_head[1] = fifo_data1;
  assign w_head[2] = fifo_data2;
  assign w_head[3] = fifo_data3;

  // The head word of an empty FIFO never influences eligibility.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = !fifo_empty[i] && !dest_almost_full[w_head[i][5:4]];
    end
  end

`ifdef ARB_STRICT_PRIO_EN
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] r_last_grant;
  logic [1:0] w_cand;

  // Scan from lowest to highest priority so the last hit is the nearest index after r_last_grant.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
    w_cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_last_grant + 2'(k);
      if (w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 2'd3;
    end else if (w_gnt_vld) begin
      r_last_grant <= w_gnt_idx;
    end
  end
`endif

  assign pop = (w_gnt_vld && !reset) ? (4'b0001 << w_gnt_idx) : 4'b0000;

  always_comb begin
    if (w_gnt_vld || (fifo_empty == 4'hF)) begin
      w_cnt_nxt = 8'h00;
    end else if (r_stall_cnt == 8'hFF) begin
      w_cnt_nxt = 8'hFF;
    end else begin
      w_cnt_nxt = r_stall_cnt + 8'd1;
    end
  end

  // Stage p1: registered push, word and FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_push_p1   <= 1'b0;
      r_data_p1   <= 6'd0;
      r_dsel_p1   <= 2'd0;
      r_stall_cnt <= 8'h00;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_cnt_nxt;
      r_stall_err <= (w_cnt_nxt == 8'hFF);
      r_push_p1   <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_state   <= ST_RUN;
        r_data_p1 <= w_head[w_gnt_idx];
        r_dsel_p1 <= w_head[w_gnt_idx][5:4];
      end else if (fifo_empty == 4'hF) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= ST_PAUSE;
      end
    end
  end

  assign push      = r_push_p1;
  assign data_out  = r_data_p1;
  assign dest_sel  = r_dsel_p1;
  assign state     = r_state;
  assign stall_err = r_stall_err;

endmodule
